// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register file: register addresses, SR/Cause
// field positions, exception codes and the EPC alignment helper.
package cp0_pkg;

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LO    = 10;
    localparam int CAUSE_BD = 31;
    localparam int EXC_LO   = 2;
    localparam int EXC_HI   = 6;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // A delay-slot victim restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] vpc, input logic bd);
        logic [31:0] base;
        base = bd ? (vpc - 32'd4) : vpc;
        return {base[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Multi-flop synchroniser chain for asynchronous level inputs.
module cp0_irq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_p0 <= '0;
        end else begin
            chain_p0 <= {chain_p0[STAGES-2:0], d};
        end
    end

    assign q = chain_p0[STAGES-1];

endmodule

// File: rtl/cp0_irq.sv
// Coprocessor-0 register file with interrupt/exception arbitration,
// synchronised hardware interrupts and a Count/Compare timer.
module cp0_irq
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT   = 6,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMER_LINE  = 5,
    parameter logic [31:0] PRID        = 32'h4350_5530
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 En,
    input  logic [4:0]           CP0Add,
    input  logic [31:0]          CP0In,
    output logic [31:0]          CP0Out,
    input  logic [31:0]          VPC,
    input  logic                 BDIn,
    input  logic [4:0]           ExcCodeIn,
    input  logic                 EXLClr,
    input  logic [NUM_HWINT-1:0] HWInt,
    output logic [31:0]          EPCOut,
    output logic                 Req,
    output logic                 TimerIrq
);

    localparam logic [NUM_HWINT-1:0] TIMER_MASK = NUM_HWINT'(1) << TIMER_LINE;

    logic [NUM_HWINT-1:0] hw_sync;
    logic [NUM_HWINT-1:0] ip_hw;
    logic [NUM_HWINT-1:0] ip;
    logic [NUM_HWINT-1:0] im;
    logic                 ie;
    logic                 exl;
    logic                 bd;
    logic [4:0]           exc_code;
    logic [31:0]          epc;
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 timer_flag;

    logic int_req;
    logic exc_req;
    logic wr;
    logic wr_sr;
    logic wr_epc;
    logic wr_count;
    logic wr_compare;
    logic timer_match;

    cp0_irq_sync #(
        .WIDTH  (NUM_HWINT),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (Clk),
        .rst (Reset),
        .d   (HWInt),
        .q   (hw_sync)
    );

    assign ip = ip_hw | (timer_flag ? TIMER_MASK : '0);

    assign int_req = ie & ~exl & (|(ip & im));
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
    // Gated by Reset so the request drops the moment reset is asserted,
    // even while an exception code is still being presented.
    assign Req     = ~Reset & (int_req | exc_req);

    assign wr         = En & ~Req;
    assign wr_sr      = wr && (CP0Add == ADDR_SR);
    assign wr_epc     = wr && (CP0Add == ADDR_EPC);
    assign wr_count   = wr && (CP0Add == ADDR_COUNT);
    assign wr_compare = wr && (CP0Add == ADDR_COMPARE);

    assign timer_match = (compare != 32'd0) && (count == compare);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ip_hw      <= '0;
            im         <= '0;
            ie         <= 1'b0;
            exl        <= 1'b0;
            bd         <= 1'b0;
            exc_code   <= 5'd0;
            epc        <= 32'd0;
            count      <= 32'd0;
            compare    <= 32'd0;
            timer_flag <= 1'b0;
        end else begin
            ip_hw <= hw_sync;
            count <= wr_count ? CP0In : (count + 32'd1);

            if (wr_compare) begin
                compare <= CP0In;
            end
            // Rewriting Compare acknowledges the timer, even against a match.
            if (wr_compare) begin
                timer_flag <= 1'b0;
            end else if (timer_match) begin
                timer_flag <= 1'b1;
            end

            if (wr_sr) begin
                im <= CP0In[IM_LO +: NUM_HWINT];
                ie <= CP0In[SR_IE];
            end
            if (wr_epc) begin
                epc <= CP0In;
            end

            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? EXC_INT : ExcCodeIn;
                bd       <= BDIn;
                epc      <= epc_of(VPC, BDIn);
            end else if (EXLClr) begin
                exl <= 1'b0;
            end else if (wr_sr) begin
                exl <= CP0In[SR_EXL];
            end
        end
    end

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            ADDR_COUNT:   CP0Out = count;
            ADDR_COMPARE: CP0Out = compare;
            ADDR_SR: begin
                CP0Out[IM_LO +: NUM_HWINT] = im;
                CP0Out[SR_EXL]             = exl;
                CP0Out[SR_IE]              = ie;
            end
            ADDR_CAUSE: begin
                CP0Out[CAUSE_BD]           = bd;
                CP0Out[IM_LO +: NUM_HWINT] = ip;
                CP0Out[EXC_HI:EXC_LO]      = exc_code;
            end
            ADDR_EPC:     CP0Out = epc;
            ADDR_PRID:    CP0Out = PRID;
            default:      CP0Out = 32'd0;
        endcase
    end

    assign EPCOut   = epc;
    assign TimerIrq = timer_flag;

endmodule

// File: tb/tb_cp0_irq.sv
// Scoreboard bench for cp0_irq: expected exception records are queued when
// the triggering stimulus is driven and checked once the exception is taken.
module tb_cp0_irq;

    localparam int          NH       = 6;
    localparam int          SS       = 2;
    localparam logic [31:0] PRID_EXP = 32'h4350_5530;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          En;
    logic [4:0]    CP0Add;
    logic [31:0]   CP0In;
    logic [31:0]   CP0Out;
    logic [31:0]   VPC;
    logic          BDIn;
    logic [4:0]    ExcCodeIn;
    logic          EXLClr;
    logic [NH-1:0] HWInt;
    logic [31:0]   EPCOut;
    logic          Req;
    logic          TimerIrq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] epc;
        logic [4:0]  code;
        logic        bd;
    } exc_t;

    exc_t sb[$];

    cp0_irq #(
        .NUM_HWINT   (NH),
        .SYNC_STAGES (SS),
        .TIMER_LINE  (5),
        .PRID        (PRID_EXP)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .EXLClr    (EXLClr),
        .HWInt     (HWInt),
        .EPCOut    (EPCOut),
        .Req       (Req),
        .TimerIrq  (TimerIrq)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
        CP0Add = a;
        #1;
        d = CP0Out;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
        En = 1'b1;
        CP0Add = a;
        CP0In = v;
        @(negedge Clk);
        En = 1'b0;
    endtask

    task automatic eret();
        EXLClr = 1'b1;
        @(negedge Clk);
        EXLClr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp;
        Reset = 1'b1; En = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; HWInt = '0;
        BDIn = 1'b0; VPC = 32'd0; CP0In = 32'd0; CP0Add = 5'd0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", Req); end
        checks++;
        if (TimerIrq !== 1'b0) begin errors++; $display("FAIL reset_timer: got %b want 0", TimerIrq); end
        checks++;
        if (EPCOut !== 32'd0) begin errors++; $display("FAIL reset_epc: got %h want 0", EPCOut); end
        for (int a = 0; a < 32; a++) begin
            mfc0(5'(a), d);
            exp = (a == 15) ? PRID_EXP : 32'd0;
            checks++;
            if (d !== exp) begin errors++; $display("FAIL reset_read[%0d]: got %h want %h", a, d, exp); end
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_regs();
        logic [31:0] d;
        En = 1'b1; CP0Add = 5'd14; CP0In = 32'h1234_5678;
        #1;
        checks++;
        if (CP0Out !== 32'd0) begin errors++; $display("FAIL same_cycle_read: got %h want 0", CP0Out); end
        @(negedge Clk);
        En = 1'b0;
        mfc0(5'd14, d);
        checks++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL epc_rw: got %h want 12345678", d); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        mfc0(5'd13, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL cause_ro: got %h want 0", d); end
        mtc0(5'd12, 32'hFFFF_FFFF);
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'h0000_FC03) begin errors++; $display("FAIL sr_mask: got %h want 0000fc03", d); end
        mtc0(5'd12, 32'd0);
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL sr_clear: got %h want 0", d); end
        mtc0(5'd3, 32'hFFFF_FFFF);
        mfc0(5'd3, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unmapped: got %h want 0", d); end
        mtc0(5'd11, 32'h0000_ABCD);
        mfc0(5'd11, d);
        checks++;
        if (d !== 32'h0000_ABCD) begin errors++; $display("FAIL compare_rw: got %h want 0000abcd", d); end
        mtc0(5'd11, 32'd0);
        mtc0(5'd9, 32'd100);
        mfc0(5'd9, d);
        checks++;
        if (d !== 32'd100) begin errors++; $display("FAIL count_load: got %0d want 100", d); end
        @(negedge Clk);
        mfc0(5'd9, d);
        checks++;
        if (d !== 32'd101) begin errors++; $display("FAIL count_inc: got %0d want 101", d); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        @(negedge Clk);
        mfc0(5'd9, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL count_wrap: got %h want 0", d); end
    endtask

    task automatic test_hwint();
        logic [31:0] d;
        exc_t e;
        mtc0(5'd12, 32'h0000_0401);
        VPC = 32'h0000_1003; BDIn = 1'b0;
        HWInt[0] = 1'b1;
        sb.push_back('{epc: 32'h0000_1000, code: 5'd0, bd: 1'b0});
        for (int k = 1; k <= SS + 1; k++) begin
            @(negedge Clk);
            checks++;
            if (Req !== (k == SS + 1)) begin
                errors++; $display("FAIL hwint_latency[%0d]: got %b want %b", k, Req, (k == SS + 1));
            end
        end
        @(negedge Clk);
        e = sb.pop_front();
        checks++;
        if (EPCOut !== e.epc) begin errors++; $display("FAIL hwint_epc: got %h want %h", EPCOut, e.epc); end
        mfc0(5'd13, d);
        checks++;
        if (d[6:2] !== e.code || d[31] !== e.bd) begin
            errors++; $display("FAIL hwint_cause: got %h want code %0d bd %b", d, e.code, e.bd);
        end
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'h0000_0403) begin errors++; $display("FAIL hwint_exl: got %h want 00000403", d); end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++;
            if (Req !== 1'b0) begin errors++; $display("FAIL hwint_masked[%0d]: got %b want 0", k, Req); end
        end
        eret();
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL hwint_after_eret: got %b want 1", Req); end
        sb.push_back('{epc: 32'h0000_1000, code: 5'd0, bd: 1'b0});
        @(negedge Clk);
        e = sb.pop_front();
        mfc0(5'd12, d);
        checks++;
        if (d[1] !== 1'b1 || EPCOut !== e.epc) begin
            errors++; $display("FAIL hwint_retake: got sr %h epc %h want exl 1 epc %h", d, EPCOut, e.epc);
        end
        HWInt = '0;
        repeat (SS + 2) @(negedge Clk);
        eret();
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'h0000_0401 || Req !== 1'b0) begin
            errors++; $display("FAIL hwint_eret: got sr %h req %b want 00000401 req 0", d, Req);
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        exc_t e;
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (5) @(negedge Clk);
        mfc0(5'd9, d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL timer_count5: got %0d want 5", d); end
        mtc0(5'd11, 32'd5);
        checks++;
        if (TimerIrq !== 1'b0 || Req !== 1'b0) begin
            errors++; $display("FAIL timer_clear_wins: got irq %b req %b want 0 0", TimerIrq, Req);
        end
        VPC = 32'h0000_4000;
        sb.push_back('{epc: 32'h0000_4000, code: 5'd0, bd: 1'b0});
        mtc0(5'd9, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            checks++;
            if (TimerIrq !== (k == 6) || Req !== (k == 6)) begin
                errors++; $display("FAIL timer_fire[%0d]: got irq %b req %b want %b", k, TimerIrq, Req, (k == 6));
            end
        end
        @(negedge Clk);
        e = sb.pop_front();
        mfc0(5'd13, d);
        checks++;
        if (EPCOut !== e.epc || d[6:2] !== e.code || d[15] !== 1'b1) begin
            errors++; $display("FAIL timer_exc: got epc %h cause %h want epc %h code %0d ip5 1", EPCOut, d, e.epc, e.code);
        end
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'h0000_8003 || TimerIrq !== 1'b1) begin
            errors++; $display("FAIL timer_sticky: got sr %h irq %b want 00008003 1", d, TimerIrq);
        end
        mtc0(5'd11, 32'h1000_0000);
        checks++;
        if (TimerIrq !== 1'b0) begin errors++; $display("FAIL timer_ack: got %b want 0", TimerIrq); end
        eret();
        mfc0(5'd13, d);
        checks++;
        if (d[15] !== 1'b0 || Req !== 1'b0) begin
            errors++; $display("FAIL timer_idle: got cause %h req %b want ip5 0 req 0", d, Req);
        end
    endtask

    task automatic test_exc_bd();
        logic [31:0] d;
        exc_t e;
        VPC = 32'h0000_3010; BDIn = 1'b1; ExcCodeIn = 5'd12;
        sb.push_back('{epc: 32'h0000_300C, code: 5'd12, bd: 1'b1});
        #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b want 1", Req); end
        @(negedge Clk);
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        e = sb.pop_front();
        checks++;
        if (EPCOut !== e.epc) begin errors++; $display("FAIL exc_bd_epc: got %h want %h", EPCOut, e.epc); end
        mfc0(5'd13, d);
        checks++;
        if (d !== {e.bd, 24'd0, e.code, 2'b00}) begin
            errors++; $display("FAIL exc_bd_cause: got %h want %h", d, {e.bd, 24'd0, e.code, 2'b00});
        end
        eret();
        mfc0(5'd12, d);
        checks++;
        if (d[1] !== 1'b0) begin errors++; $display("FAIL exc_eret: got exl %b want 0", d[1]); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        exc_t e;
        mtc0(5'd12, 32'h0000_0401);
        VPC = 32'h0000_5008;
        HWInt[0] = 1'b1;
        repeat (SS + 1) @(negedge Clk);
        ExcCodeIn = 5'd4;
        En = 1'b1; CP0Add = 5'd14; CP0In = 32'hDEAD_BEEF;
        sb.push_back('{epc: 32'h0000_5008, code: 5'd0, bd: 1'b0});
        #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", Req); end
        @(negedge Clk);
        En = 1'b0; ExcCodeIn = 5'd0;
        e = sb.pop_front();
        checks++;
        if (EPCOut !== e.epc) begin errors++; $display("FAIL prio_write_dropped: got %h want %h", EPCOut, e.epc); end
        mfc0(5'd13, d);
        checks++;
        if (d[6:2] !== e.code || d[31] !== e.bd) begin
            errors++; $display("FAIL prio_code: got %h want code %0d", d, e.code);
        end
        HWInt = '0;
        repeat (SS + 2) @(negedge Clk);
        eret();
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        exc_t e;
        VPC = 32'h0000_6000; ExcCodeIn = 5'd5; EXLClr = 1'b1;
        sb.push_back('{epc: 32'h0000_6000, code: 5'd5, bd: 1'b0});
        #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL simul_req: got %b want 1", Req); end
        @(negedge Clk);
        ExcCodeIn = 5'd0; EXLClr = 1'b0;
        e = sb.pop_front();
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'h0000_0403) begin errors++; $display("FAIL simul_exl: got %h want 00000403", d); end
        mfc0(5'd13, d);
        checks++;
        if (d[6:2] !== e.code || EPCOut !== e.epc) begin
            errors++; $display("FAIL simul_cause: got cause %h epc %h want code %0d epc %h", d, EPCOut, e.code, e.epc);
        end
        En = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0803; EXLClr = 1'b1;
        @(negedge Clk);
        En = 1'b0; EXLClr = 1'b0;
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'h0000_0801) begin errors++; $display("FAIL sr_vs_eret: got %h want 00000801", d); end
        ExcCodeIn = 5'd10;
        #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b want 1", Req); end
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL reset_req_drop: got %b want 0", Req); end
        mfc0(5'd12, d);
        checks++;
        if (d !== 32'd0 || EPCOut !== 32'd0) begin
            errors++; $display("FAIL reset_async_state: got sr %h epc %h want 0 0", d, EPCOut);
        end
        ExcCodeIn = 5'd0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_regs();
        test_hwint();
        test_timer();
        test_exc_bd();
        test_priority();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_irq.md
Name: cp0_irq

Overview:
- Parametrised successor to the single-cycle CP0: the coprocessor-0 register file with exception and interrupt arbitration.
- Adds NUM_HWINT external interrupt lines, each with a synchroniser.
- Adds a Count/Compare timer whose sticky interrupt is merged onto one line.
- Adds branch-delay (BD) tracking and a read-only PRId register.
- Sits beside the datapath: receives the victim PC and exception code; drives Req to the control unit and EPCOut to the NPC.

Parameters:
- NUM_HWINT, 6, number of hardware interrupt lines, legal 1..6; mapped to IP/IM bits [10+NUM_HWINT-1:10].
- SYNC_STAGES, 2, flop stages per HWInt synchroniser, legal >=2.
- TIMER_LINE, 5, IP index (0..NUM_HWINT-1) that receives the timer interrupt.
- PRID, 32'h4350_5530, constant value read from register 15.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  mtc0 write strobe.
- CP0Add  in  5  register address for mtc0/mfc0.
- CP0In  in  32  mtc0 write data.
- CP0Out  out  32  mfc0 read data, combinational.
- VPC  in  32  PC of the instruction in this cycle.
- BDIn  in  1  this instruction sits in a branch delay slot.
- ExcCodeIn  in  5  synchronous exception code; 0 means none.
- EXLClr  in  1  eret strobe.
- HWInt  in  NUM_HWINT  asynchronous level interrupt lines.
- EPCOut  out  32  current EPC register.
- Req  out  1  take exception/interrupt this cycle, combinational.
- TimerIrq  out  1  sticky timer-pending flag.

Behaviour:
Registers and reset
- Reset forces SR=0, Cause=0, EPC=0, Count=0, Compare=0, timer flag=0 and all synchroniser flops=0.
- SR (12): IM [15:10], EXL bit1, IE bit0; all other bits read 0.
- Cause (13): BD bit31, IP [15:10], ExcCode [6:2]; not writable by mtc0.
- EPC (14): fully writable.
- PRId (15): reads PRID.
- Count (9) and Compare (11): fully writable.
- Any other address reads 0 and ignores writes.

Interrupt path
- HWInt passes through SYNC_STAGES flops, then is registered into IP every cycle (level, not latched).
- IP[TIMER_LINE] = synced HWInt[TIMER_LINE] OR timer flag.

Timer
- Count increments by 1 every cycle and wraps 32'hFFFF_FFFF->0.
- An mtc0 to Count loads CP0In instead of incrementing.
- When Compare!=0 and Count==Compare, the timer flag sets on the next edge.
- Any mtc0 to Compare clears the flag; a clear in the same cycle as a match wins.

Request logic
- IntReq = IE & ~EXL & |(IP & IM).
- ExcReq = (ExcCodeIn!=0) & ~EXL.
- Req = IntReq | ExcReq. When both are true, the interrupt has priority.

On an edge with Req=1
- EXL<=1.
- ExcCode<=0 for an interrupt, otherwise ExcCodeIn.
- BD<=BDIn.
- EPC<= (BDIn ? VPC-4 : VPC) with bits [1:0] forced to 0.

Simultaneous events
- Req and En in the same cycle: the write is dropped.
- Req and EXLClr in the same cycle: Req wins and EXL stays 1.
- EXLClr alone: EXL<=0 on the next edge.
- mtc0 to SR and EXLClr in the same cycle: EXLClr wins for the EXL bit; the other bits take CP0In.

Reads and reset timing
- mfc0 reads are combinational and return pre-edge values, so a same-cycle write is not visible.
- Reset asserted mid-operation clears state immediately; Req drops combinationally.

Decomposition:
- cp0_pkg holds:
  - Register address constants 9, 11, 12, 13, 14, 15.
  - SR/Cause bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- One sub-module, cp0_irq_sync: a parametrised-depth synchroniser chain, instantiated once with width NUM_HWINT.

Test Plan:
1. Reset, then mfc0 to every address -> all read 0 except PRId = 32'h4350_5530.
2. SR=32'h0000_0401 (IM0, IE); raise HWInt[0] -> Req rises exactly SYNC_STAGES+1 cycles later. Then check EPC=VPC&~3, ExcCode=0, EXL=1. Req then stays 0 until eret.
3. ExcCodeIn=12 with BDIn=1 at VPC=32'h0000_3010 -> EPC=32'h0000_300C, Cause.BD=1, ExcCode=12.
4. Compare=5, SR=32'h0000_8001 (IM5, IE) -> TimerIrq sets on the edge where Count==5 and Req fires. A write to Compare then clears TimerIrq.
5. HWInt pending and ExcCodeIn=4 in the same cycle -> ExcCode=0 (interrupt wins). Also, an mtc0 to EPC in the Req cycle is dropped.
6. EXLClr and ExcCodeIn=5 in the same cycle -> EXL stays 1 and ExcCode=5. Reset asserted mid-cycle -> Req=0 immediately.
